// File: rtl/boa_muldiv_seq.sv
// Sequenced RV32M unit: registered multiplier with fixed MUL_LAT latency, 1-bit/cycle restoring divider.
// Optional last-division result cache enabled by defining BOA_MULDIV_CACHE_EN.
module boa_muldiv_seq #(
  parameter int MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  funct3,
  input  logic [31:0] lhs,
  input  logic [31:0] rhs,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res,
  output logic        busy
);

  localparam int DATA_W = 32;
  localparam logic [1:0] MUL_LAST = 2'(MUL_LAT - 2);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  function automatic logic [DATA_W-1:0] mul_sel(input logic [2:0] f,
                                                input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    logic signed [DATA_W:0]     a_x;
    logic signed [DATA_W:0]     b_x;
    logic signed [2*DATA_W-1:0] p;
    a_x = signed'({(f[1:0] != 2'd3) & a[DATA_W-1], a});
    b_x = signed'({~f[1] & b[DATA_W-1], b});
    p   = 64'(a_x) * 64'(b_x);
    return (f[1:0] == 2'd0) ? p[DATA_W-1:0] : p[2*DATA_W-1:DATA_W];
  endfunction

  function automatic logic [DATA_W-1:0] neg_if(input logic neg, input logic [DATA_W-1:0] v);
    return neg ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [DATA_W-1:0] abs_if(input logic sgn, input logic [DATA_W-1:0] v);
    return neg_if(sgn & v[DATA_W-1], v);
  endfunction

  state_t state, state_nxt;

  logic              accept;
  logic              div_sgn_in;
  logic              dbz_in;
  logic              ovf_in;
  logic              fast_in;
  logic              hit_in;
  logic [DATA_W-1:0] fast_res_in;
  logic [DATA_W-1:0] hit_res_in;

  logic [1:0]        op_p0;
  logic [DATA_W-1:0] lhs_p0;
  logic [DATA_W-1:0] rhs_p0;
  logic [DATA_W-1:0] mul_p1;
  logic [1:0]        mul_cnt;
  logic [5:0]        div_cnt;
  logic [DATA_W-1:0] quo_p1;
  logic [DATA_W-1:0] rem_p1;
  logic [DATA_W-1:0] dsr_p1;
  logic              q_neg_p1;
  logic              r_neg_p1;

  logic [DATA_W:0]   shl;
  logic              qbit;
  logic [DATA_W-1:0] rem_sub;
  logic [DATA_W-1:0] rem_nxt;
  logic [DATA_W-1:0] quo_nxt;
  logic [DATA_W-1:0] quo_fin;
  logic [DATA_W-1:0] rem_fin;
  logic              div_last;
  logic              mul_last;

  assign accept      = req_valid && req_ready;
  assign div_sgn_in  = ~funct3[0];
  assign dbz_in      = (rhs == '0);
  assign ovf_in      = div_sgn_in && (lhs == 32'h8000_0000) && (rhs == 32'hFFFF_FFFF);
  assign fast_in     = funct3[2] && (dbz_in || ovf_in);
  assign fast_res_in = dbz_in ? (funct3[1] ? lhs : 32'hFFFF_FFFF)
                              : (funct3[1] ? 32'h0 : 32'h8000_0000);

`ifdef BOA_MULDIV_CACHE_EN
  logic              cache_vld;
  logic              cache_sgn;
  logic [DATA_W-1:0] cache_lhs;
  logic [DATA_W-1:0] cache_rhs;
  logic [DATA_W-1:0] cache_quo;
  logic [DATA_W-1:0] cache_rem;

  always_ff @(posedge clk) begin
    if (rst)
      cache_vld <= 1'b0;
    else if (div_last && !flush)
      cache_vld <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (div_last && !flush) begin
      cache_sgn <= op_p0[0];
      cache_lhs <= lhs_p0;
      cache_rhs <= rhs_p0;
      cache_quo <= quo_fin;
      cache_rem <= rem_fin;
    end
  end

  assign hit_in     = funct3[2] && !fast_in && cache_vld && (cache_sgn == funct3[0]) &&
                      (lhs == cache_lhs) && (rhs == cache_rhs);
  assign hit_res_in = funct3[1] ? cache_rem : cache_quo;
`else
  assign hit_in     = 1'b0;
  assign hit_res_in = '0;
`endif

  assign req_ready = (state == IDLE) && !flush;
  assign busy      = (state != IDLE);
  assign res_valid = (state == DONE);
  assign div_last  = (state == DIV) && (div_cnt == 6'd32);
  assign mul_last  = (state == MUL) && (mul_cnt == MUL_LAST);

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (!funct3[2])
            state_nxt = (MUL_LAT == 1) ? DONE : MUL;
          else if (fast_in || hit_in)
            state_nxt = DONE;
          else
            state_nxt = DIV;
        end
      end
      MUL:  if (mul_last) state_nxt = DONE;
      DIV:  if (div_last) state_nxt = DONE;
      DONE: if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush)
      state_nxt = IDLE;
  end

  // Stage p0/p1: operand capture and product register at accept
  always_ff @(posedge clk) begin
    if (accept) begin
      op_p0   <= funct3[1:0];
      lhs_p0  <= lhs;
      rhs_p0  <= rhs;
      mul_p1  <= mul_sel(funct3, lhs, rhs);
      mul_cnt <= '0;
      div_cnt <= '0;
    end else begin
      if (state == MUL)
        mul_cnt <= mul_cnt + 2'd1;
      if (state == DIV)
        div_cnt <= div_cnt + 6'd1;
    end
  end

  // Restoring iteration: shift in next dividend bit, subtract when it fits
  assign shl     = {rem_p1, quo_p1[DATA_W-1]};
  assign qbit    = (shl >= {1'b0, dsr_p1});
  assign rem_sub = shl[DATA_W-1:0] - dsr_p1;
  assign rem_nxt = qbit ? rem_sub : shl[DATA_W-1:0];
  assign quo_nxt = {quo_p1[DATA_W-2:0], qbit};
  assign quo_fin = neg_if(q_neg_p1, quo_nxt);
  assign rem_fin = neg_if(r_neg_p1, rem_nxt);

  always_ff @(posedge clk) begin
    if (state == DIV) begin
      if (div_cnt == 6'd0) begin
        quo_p1   <= abs_if(~op_p0[0], lhs_p0);
        dsr_p1   <= abs_if(~op_p0[0], rhs_p0);
        rem_p1   <= '0;
        q_neg_p1 <= ~op_p0[0] & (lhs_p0[DATA_W-1] ^ rhs_p0[DATA_W-1]);
        r_neg_p1 <= ~op_p0[0] & lhs_p0[DATA_W-1];
      end else begin
        quo_p1 <= quo_nxt;
        rem_p1 <= rem_nxt;
      end
    end
  end

  // Result register feeding writeback
  always_ff @(posedge clk) begin
    if (rst)
      res <= '0;
    else if (!flush) begin
      if (accept && fast_in)
        res <= fast_res_in;
      else if (accept && hit_in)
        res <= hit_res_in;
      else if (accept && !funct3[2] && (MUL_LAT == 1))
        res <= mul_sel(funct3, lhs, rhs);
      else if (mul_last)
        res <= mul_p1;
      else if (div_last)
        res <= op_p0[1] ? rem_fin : quo_fin;
    end
  end

endmodule

// File: doc/boa_muldiv_seq.md
Name: boa_muldiv_seq

Overview:
- Sequenced RV32M execution unit sitting directly downstream of the decode/operand-forwarding stage.
- Accepts M-extension operations over a valid/ready handshake and latches operands.
- Multiplies using a registered multiplier pipeline; divides with a 1-bit/cycle restoring divider.
- Presents one 32-bit result to writeback over a second valid/ready handshake; applies RISC-V divide-by-zero and signed-overflow rules.

Parameters:
- MUL_LAT, 2, cycles from request accept to res_valid for MUL/MULH/MULHSU/MULHU; legal range 1..4.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- flush  input  1  synchronous abort of any in-flight operation (pipeline flush).
- req_valid  input  1  operation request present.
- req_ready  output  1  unit can accept a request this cycle.
- funct3  input  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- lhs  input  32  rs1 operand.
- rhs  input  32  rs2 operand.
- res_valid  output  1  result present.
- res_ready  input  1  writeback consumes the result this cycle.
- res  output  32  operation result.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: state IDLE; res_valid 0; res 0; busy 0; req_ready 1. Divider registers are don't-care.
- States are IDLE, MUL, DIV, DONE.
- req_ready = (state==IDLE) && !flush.
- Accept: req_valid && req_ready in cycle N latches funct3, lhs and rhs. Later input changes are ignored.
- IDLE -> MUL when funct3[2]==0.
- IDLE -> DIV when funct3[2]==1 and the operands are normal (not a fast case).
- IDLE -> DONE when funct3[2]==1 and the operands hit a fast case.
- MUL: result-valid timing is fixed.
  - res_valid rises at N+MUL_LAT.
  - Operands are sign-extended per the operation: MUL/MULH both signed, MULHSU lhs signed and rhs unsigned, MULHU both unsigned.
  - MUL returns product[31:0]; the others return product[63:32].
- DIV normal path:
  - Cycle N+1: take absolute values (signed ops only); record quotient sign = sign(lhs)^sign(rhs) and remainder sign = sign(lhs).
  - Cycles N+2..N+33: 32 restoring iterations, MSB first.
  - Cycle N+34: sign correction; res_valid rises.
- Fast cases, all with res_valid at N+1:
  - Divide by zero (rhs==0): quotient 0xFFFF_FFFF for both DIV and DIVU; remainder = lhs.
  - Signed overflow (DIV/REM, lhs 0x8000_0000, rhs 0xFFFF_FFFF): quotient 0x8000_0000; remainder 0.
- DONE: res and res_valid hold stable until res_ready. On res_valid && res_ready the unit goes to IDLE.
  - The next request can be accepted the cycle after the transfer; there is no same-cycle re-accept.
- flush: in any state, next state IDLE and res_valid 0.
  - Any pending result is discarded, including one held in DONE whose res_ready was not asserted.
  - A request presented in the flush cycle is not accepted, since req_ready is 0.
- rst mid-operation behaves as flush and also clears res.
- flush and rst override res_ready.
- All arithmetic is modulo 2^32 except the 64-bit high product. No exceptions are raised.

Optional Feature:
- Macro: BOA_MULDIV_CACHE_EN.
- Defined: the unit keeps one entry holding signedness, lhs, rhs, quotient and remainder of the last normal-path division that reached DONE.
  - A later DIV/DIVU/REM/REMU with matching signedness (funct3[0]), lhs and rhs goes IDLE -> DONE with res_valid at N+1, returning the cached quotient or remainder per funct3[1].
  - The entry is invalidated by rst only; flush does not clear it.
  - A flushed division does not update it.
  - Fast-case divisions neither hit nor update it.
- Undefined: no cache storage. Every normal division takes the full 34 cycles.

Test Plan:
- Multiply: MULHSU lhs=0xFFFF_FFFF, rhs=0x0000_0002, MUL_LAT=2 -> res_valid at N+2, res=0xFFFF_FFFF; MUL same operands -> 0xFFFF_FFFE.
- Divide: DIV lhs=0xFFFF_FFF9 (-7), rhs=2 -> res_valid at N+34, res=0xFFFF_FFFD (-3); REM same operands -> 0xFFFF_FFFF (-1).
- Fast cases:
  - DIVU lhs=0x1234, rhs=0 -> N+1, res=0xFFFF_FFFF; REMU same -> 0x1234.
  - DIV lhs=0x8000_0000, rhs=0xFFFF_FFFF -> N+1, res=0x8000_0000; REM same -> 0.
- Backpressure: DIV 100/7 with res_ready held low for 10 cycles after res_valid -> res=14 stable throughout, req_ready 0, busy 1; one res_ready pulse -> IDLE next cycle.
- Flush and reset:
  - flush at N+10 of a division -> IDLE next cycle, no res_valid ever for that op; following MUL 3*5 -> res=15.
  - rst asserted during MUL -> res_valid 0, res 0.
- Cache (BOA_MULDIV_CACHE_EN): DIVU 1000/3 (34 cycles, res=333), then REMU 1000/3 -> N+1, res=1; then REM 1000/3 (signedness differs) -> 34 cycles, res=1. Without the macro, the REMU takes 34 cycles.
